// File: rtl/bit_scatter_seq_pkg.sv
// rtl/bit_scatter_seq_pkg.sv - shared types and constants for the line-scatter sequencer
//
// Purpose: FSM state encoding, default geometry and output reset values
// shared by the sequencer and anything that needs to talk about its states.

package bit_scatter_seq_pkg;

    // Default geometry: 16 decoder lines addressed by a 4-bit index.
    localparam int N_LINES_DEF = 16;
    localparam int SEL_W_DEF   = 4;

    // Values presented to the decoder while idle or after reset.
    localparam int   SEL_RST = 0;
    localparam logic VAL_RST = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_scatter_seq.sv
// rtl/bit_scatter_seq.sv - walks a masked data word onto a 1-to-16 line decoder
//
// Purpose: accepts one {data, mask} word, then presents line indices
// 0..N_LINES-1 on consecutive cycles, pulsing strobe for each masked line
// with that line's data bit on val. Ends with a one-cycle done pulse that
// carries the number of strobes issued. abort cancels a scan in progress.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   in_valid    request present
//   in_ready    block can accept a request (idle and not in reset)
//   in_data     bit i is the value for line i
//   in_mask     bit i set means line i is driven
//   abort       cancel the current scan (only honoured while scanning)
//   sel         registered line index to the decoder
//   val         registered bit value to the decoder
//   strobe      registered, sel/val valid for a masked line this cycle
//   done        registered one-cycle completion pulse
//   strobe_cnt  strobes issued; final value valid while done is high

module bit_scatter_seq
    import bit_scatter_seq_pkg::*;
#(
    parameter int N_LINES = N_LINES_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_LINES-1:0] in_data,
    input  logic [N_LINES-1:0] in_mask,
    input  logic               abort,
    output logic [SEL_W-1:0]   sel,
    output logic               val,
    output logic               strobe,
    output logic               done,
    output logic [SEL_W:0]     strobe_cnt
);

    state_t             r_state;
    logic [N_LINES-1:0] r_data;
    logic [N_LINES-1:0] r_mask;
    logic [SEL_W-1:0]   r_idx;
    logic               r_val;
    logic               r_strobe;
    logic               r_done;
    logic [SEL_W:0]     r_cnt;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic               w_val_nxt;
    logic               w_strobe_nxt;
    logic               w_done_nxt;
    logic [SEL_W:0]     w_cnt_nxt;
    logic               w_capture;
    logic               w_ready;
    logic               w_accept;
    logic               w_last;
    logic [SEL_W-1:0]   w_idx_inc;

    // Ready is forced low while rst is asserted so nothing is accepted in
    // the reset cycle even though the state register already reads IDLE.
    assign w_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept  = in_valid && w_ready;
    assign w_last    = (r_idx == SEL_W'(N_LINES - 1));
    assign w_idx_inc = r_idx + 1'b1;

    // The outputs are registered, so each edge loads the decoder values for
    // the cycle that follows it. The accept edge therefore already loads
    // line 0, and every scan edge loads line idx+1. sel always equals idx.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_val_nxt    = r_val;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_capture    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_capture = 1'b1;
                    w_idx_nxt = '0;
                    if (in_mask == '0) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt  = ST_SCAN;
                        w_strobe_nxt = in_mask[0];
                        if (in_mask[0]) begin
                            w_val_nxt = in_data[0];
                        end
                        w_cnt_nxt = {{SEL_W{1'b0}}, in_mask[0]};
                    end
                end
            end

            ST_SCAN: begin
                if (abort) begin
                    // Drop everything: no further strobes, no done, count discarded.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt    = w_idx_inc;
                    w_strobe_nxt = r_mask[w_idx_inc];
                    if (r_mask[w_idx_inc]) begin
                        w_val_nxt = r_data[w_idx_inc];
                    end
                    w_cnt_nxt = r_cnt + {{SEL_W{1'b0}}, r_mask[w_idx_inc]};
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_mask   <= '0;
            r_idx    <= SEL_W'(SEL_RST);
            r_val    <= VAL_RST;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_capture) begin
                r_data <= in_data;
                r_mask <= in_mask;
            end
            r_idx    <= w_idx_nxt;
            r_val    <= w_val_nxt;
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign in_ready   = w_ready;
    assign sel        = r_idx;
    assign val        = r_val;
    assign strobe     = r_strobe;
    assign done       = r_done;
    assign strobe_cnt = r_cnt;

endmodule
